// File: rtl/alu16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu16_pkg
// Purpose  : Shared types and constants for the shared-ALU arbiter slice.
//            - DW          : operand width (result is DW+1 bits)
//            - alu_op_e    : opcode encoding seen by alu16_core
//            - arb_state_e : arbiter sequencing states
//            - is_illegal_op : true for opcodes outside the defined set
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package alu16_pkg;

  localparam int DW = 16;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  // Opcodes above XOR have no defined operation and produce a zero result.
  function automatic logic is_illegal_op(input logic [2:0] sel);
    return (sel > ALU_XOR);
  endfunction

endpackage : alu16_pkg
`default_nettype wire

// File: rtl/alu16_core.sv
`default_nettype none
// ============================================================================
// Module   : alu16_core
// Purpose  : Purely combinational 16-bit ALU. Operands are zero-extended to
//            17 bits; bit 16 is the carry for ADD, the unsigned borrow
//            (a < b) for SUB, and 0 for logic ops. Opcodes 5..7 give 0.
// Ports    : a   [DW-1:0] in  - operand A
//            b   [DW-1:0] in  - operand B
//            sel [2:0]    in  - opcode (alu_op_e encoding)
//            s   [DW:0]   out - 17-bit result
// Revision : 1.0 - initial release
// ============================================================================
module alu16_core
  import alu16_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    sel,
  output logic [DW:0]   s
);

  logic [DW:0] a_ext;
  logic [DW:0] b_ext;

  assign a_ext = {1'b0, a};
  assign b_ext = {1'b0, b};

  always_comb begin
    s = '0;
    case (sel)
      ALU_ADD: s = a_ext + b_ext;
      // 17-bit wrap of the subtraction leaves bit 16 set exactly when a < b.
      ALU_SUB: s = a_ext - b_ext;
      ALU_AND: s = a_ext & b_ext;
      ALU_OR:  s = a_ext | b_ext;
      ALU_XOR: s = a_ext ^ b_ext;
      default: s = '0;
    endcase
  end

endmodule : alu16_core
`default_nettype wire

// File: rtl/alu16_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu16_arbiter
// Purpose  : Shares one alu16_core between two requesters. Round-robin
//            arbitration in IDLE, operands latched on acceptance, result
//            registered in EXEC and presented on a valid/ready response
//            channel in RESP, tagged with the requester index.
// Config   : ALU16_ARB_ERR_EN - adds rsp_err, set with the response when
//            the latched opcode is 5..7.
// Ports    : clk        in   - rising-edge clock
//            rst_n      in   - synchronous active-low reset
//            req_valid  in   [NREQ-1:0]         request valid per requester
//            req_ready  out  [NREQ-1:0]         request accepted this cycle
//            req_a      in   [NREQ-1:0][DW-1:0] operand A per requester
//            req_b      in   [NREQ-1:0][DW-1:0] operand B per requester
//            req_sel    in   [NREQ-1:0][2:0]    opcode per requester
//            rsp_valid  out  - response valid
//            rsp_ready  in   - response consumer ready
//            rsp_id     out  - requester the response belongs to
//            rsp_data   out  [DW:0] result
//            rsp_err    out  - illegal opcode (ALU16_ARB_ERR_EN only)
// Revision : 1.0 - initial release
// ============================================================================
module alu16_arbiter #(
  parameter int NREQ = 2,
  parameter int DW   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0][DW-1:0] req_a,
  input  logic [NREQ-1:0][DW-1:0] req_b,
  input  logic [NREQ-1:0][2:0]    req_sel,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_id,
  output logic [DW:0]             rsp_data
`ifdef ALU16_ARB_ERR_EN
  ,
  output logic                    rsp_err
`endif
);
  import alu16_pkg::*;

  arb_state_e    state_q;
  arb_state_e    state_d;
  logic          last_q;     // requester granted most recently
  logic          grant;      // requester selected this cycle
  logic          any_valid;
  logic          accept;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [2:0]    sel_q;
  logic          id_q;
  logic [DW:0]   alu_s;

  alu16_core u_core (
    .a   (a_q),
    .b   (b_q),
    .sel (sel_q),
    .s   (alu_s)
  );

  // Round-robin between two: on contention the requester that did not win
  // last time goes first; a lone requester always wins.
  always_comb begin
    any_valid = |req_valid;
    if (req_valid[0] && req_valid[1]) begin
      grant = ~last_q;
    end else if (req_valid[0]) begin
      grant = 1'b0;
    end else begin
      grant = 1'b1;
    end
  end

  // Next state and request handshake. Gating with rst_n keeps req_ready
  // low throughout reset cycles even though it is combinational.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rst_n && any_valid) begin
          req_ready[grant] = 1'b1;
          accept           = 1'b1;
          state_d          = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rsp_valid = (state_q == ST_RESP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      last_q   <= 1'b1;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      id_q     <= 1'b0;
      rsp_data <= '0;
      rsp_id   <= 1'b0;
`ifdef ALU16_ARB_ERR_EN
      rsp_err  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q    <= req_a[grant];
        b_q    <= req_b[grant];
        sel_q  <= req_sel[grant];
        id_q   <= grant;
        last_q <= grant;
`ifdef ALU16_ARB_ERR_EN
        rsp_err <= 1'b0;
`endif
      end
      // Response fields are captured once in EXEC and then held through
      // RESP regardless of back-pressure.
      if (state_q == ST_EXEC) begin
        rsp_data <= alu_s;
        rsp_id   <= id_q;
`ifdef ALU16_ARB_ERR_EN
        rsp_err  <= is_illegal_op(sel_q);
`endif
      end
    end
  end

endmodule : alu16_arbiter
`default_nettype wire

// File: tb/tb_alu16_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu16_arbiter
// Purpose  : Self-checking bench for alu16_arbiter. Expected results come
//            from an arithmetic reference (ref_alu) and a round-robin model
//            that only remembers who won last. Build with ALU16_ARB_ERR_EN
//            defined to also check rsp_err.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu16_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][15:0] req_a;
  logic [1:0][15:0] req_b;
  logic [1:0][2:0]  req_sel;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [16:0]      rsp_data;
`ifdef ALU16_ARB_ERR_EN
  logic             rsp_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int model_last = 1;

  always #5 clk = ~clk;

  alu16_arbiter #(.NREQ(2), .DW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sel   (req_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
`ifdef ALU16_ARB_ERR_EN
    ,
    .rsp_err   (rsp_err)
`endif
  );

  // Reference ALU: plain integer arithmetic modulo 2^17.
  function automatic logic [16:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] sel);
    int unsigned ua;
    int unsigned ub;
    ua = a;
    ub = b;
    case (sel)
      3'd0:    return 17'((ua + ub) % 131072);
      3'd1:    return 17'((ua + 131072 - ub) % 131072);
      3'd2:    return 17'(ua & ub);
      3'd3:    return 17'(ua | ub);
      3'd4:    return 17'(ua ^ ub);
      default: return 17'd0;
    endcase
  endfunction

  function automatic int ref_winner(input logic [1:0] v);
    if (v == 2'b11) return 1 - model_last;
    else if (v[0])  return 0;
    else            return 1;
  endfunction

  // Stimulus helper: present requests, wait (bounded) for a grant, and drop
  // all request valids right after the accepting edge.
  task automatic accept_one(input logic [1:0] v,
                            input logic [15:0] a0, input logic [15:0] b0, input logic [2:0] s0,
                            input logic [15:0] a1, input logic [15:0] b1, input logic [2:0] s1,
                            output logic [1:0] rdy, output bit got);
    req_a[0] = a0; req_b[0] = b0; req_sel[0] = s0;
    req_a[1] = a1; req_b[1] = b1; req_sel[1] = s1;
    req_valid = v;
    rdy = 2'b00;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        rdy = req_ready;
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 2'b00;
  endtask

  // Stimulus helper: wait (bounded) for rsp_valid, capture the response and
  // step past the handshake edge. lat counts negedges from the EXEC cycle.
  task automatic get_rsp(output bit got, output logic [16:0] d, output logic id,
                         output logic e, output int lat);
    got = 1'b0; d = '0; id = 1'b0; e = 1'b0; lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin
        got = 1'b1;
        d   = rsp_data;
        id  = rsp_id;
`ifdef ALU16_ARB_ERR_EN
        e   = rsp_err;
`endif
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    req_a     = '0;
    req_b     = '0;
    req_sel   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    n_cmp++; if (rsp_data !== 17'h0) begin n_bad++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    n_cmp++; if (rsp_id !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_id got=%b exp=0", rsp_id); end
`ifdef ALU16_ARB_ERR_EN
    n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
`endif
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    rst_n     = 1'b1;
    model_last = 1;
  endtask

  task automatic test_add_carry();
    logic [1:0] rdy; bit got; logic [16:0] d; logic id; logic e; int lat;
    accept_one(2'b01, 16'hFFFF, 16'h0001, 3'd0, 16'h0, 16'h0, 3'd0, rdy, got);
    model_last = 0;
    n_cmp++; if ({got, rdy} !== 3'b101) begin n_bad++; $display("FAIL add_grant got=%b/%b exp=1/01", got, rdy); end
    get_rsp(got, d, id, e, lat);
    n_cmp++; if (!got || lat != 2) begin n_bad++; $display("FAIL add_latency got=%0d (seen=%0d) exp=2", lat, got); end
    n_cmp++; if (d !== 17'h10000) begin n_bad++; $display("FAIL add_data got=%h exp=10000", d); end
    n_cmp++; if (id !== 1'b0) begin n_bad++; $display("FAIL add_id got=%b exp=0", id); end
  endtask

  task automatic test_sub_borrow();
    logic [1:0] rdy; bit got; logic [16:0] d; logic id; logic e; int lat;
    accept_one(2'b10, 16'h0, 16'h0, 3'd0, 16'h0003, 16'h0005, 3'd1, rdy, got);
    model_last = 1;
    n_cmp++; if ({got, rdy} !== 3'b110) begin n_bad++; $display("FAIL sub_grant got=%b/%b exp=1/10", got, rdy); end
    get_rsp(got, d, id, e, lat);
    n_cmp++; if (!got || d !== ref_alu(16'h0003, 16'h0005, 3'd1)) begin n_bad++; $display("FAIL sub_data got=%h exp=1fffe", d); end
    n_cmp++; if (id !== 1'b1) begin n_bad++; $display("FAIL sub_id got=%b exp=1", id); end
  endtask

  task automatic test_round_robin();
    bit got; logic [16:0] d; logic id; logic e; int lat; int w; logic [1:0] rdy;
    logic [16:0] exp_d;
    req_a[0] = 16'hF0F0; req_b[0] = 16'h0FF0; req_sel[0] = 3'd2;
    req_a[1] = 16'hAAAA; req_b[1] = 16'h5555; req_sel[1] = 3'd4;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      rdy = 2'b00;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (req_ready != 2'b00) begin rdy = req_ready; break; end
      end
      w = ref_winner(2'b11);
      n_cmp++; if (rdy !== ((w == 1) ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL rr_grant_%0d got=%b exp_winner=%0d", k, rdy, w); end
      model_last = w;
      @(posedge clk);
      get_rsp(got, d, id, e, lat);
      exp_d = (w == 0) ? 17'h000F0 : 17'h0FFFF;
      n_cmp++; if (!got || d !== exp_d || id !== w[0]) begin n_bad++; $display("FAIL rr_rsp_%0d got=%h/id%b exp=%h/id%0d", k, d, id, exp_d, w); end
    end
    req_valid = 2'b00;
  endtask

  task automatic test_back_pressure();
    logic [1:0] rdy; bit got; logic [16:0] d0; logic [16:0] d; logic id; logic e; int lat;
    rsp_ready = 1'b0;
    accept_one(2'b01, 16'h1234, 16'h4321, 3'd3, 16'h0, 16'h0, 3'd0, rdy, got);
    model_last = 0;
    // A second request waits while the first response is stalled.
    req_a[1] = 16'h8000; req_b[1] = 16'h8000; req_sel[1] = 3'd0;
    req_valid = 2'b10;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1'b1; break; end
    end
    d0 = rsp_data;
    n_cmp++; if (!got || d0 !== ref_alu(16'h1234, 16'h4321, 3'd3)) begin n_bad++; $display("FAIL bp_data got=%h exp=%h", d0, ref_alu(16'h1234, 16'h4321, 3'd3)); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== d0 || req_ready !== 2'b00)
        begin n_bad++; $display("FAIL bp_hold_%0d got valid=%b data=%h ready=%b exp 1/%h/00", i, rsp_valid, rsp_data, req_ready, d0); end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 2'b10) begin n_bad++; $display("FAIL bp_release got valid=%b ready=%b exp 0/10", rsp_valid, req_ready); end
    model_last = 1;
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    get_rsp(got, d, id, e, lat);
    n_cmp++; if (!got || d !== 17'h10000 || id !== 1'b1) begin n_bad++; $display("FAIL bp_second got=%h/id%b exp=10000/id1", d, id); end
  endtask

  task automatic test_illegal();
    logic [1:0] rdy; bit got; logic [16:0] d; logic id; logic e; int lat;
    accept_one(2'b01, 16'h1234, 16'h5678, 3'd6, 16'h0, 16'h0, 3'd0, rdy, got);
    model_last = 0;
    get_rsp(got, d, id, e, lat);
    n_cmp++; if (!got || d !== 17'h0) begin n_bad++; $display("FAIL illegal_data got=%h exp=0", d); end
`ifdef ALU16_ARB_ERR_EN
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL illegal_err got=%b exp=1", e); end
`endif
    accept_one(2'b10, 16'h0, 16'h0, 3'd0, 16'h00FF, 16'h0F0F, 3'd4, rdy, got);
    model_last = 1;
    get_rsp(got, d, id, e, lat);
    n_cmp++; if (!got || d !== 17'h00FF0) begin n_bad++; $display("FAIL legal_after_illegal got=%h exp=00ff0", d); end
`ifdef ALU16_ARB_ERR_EN
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL err_cleared got=%b exp=0", e); end
`endif
  endtask

  task automatic test_mid_reset();
    logic [1:0] rdy; bit got; logic [16:0] d; logic id; logic e; int lat;
    accept_one(2'b01, 16'h0100, 16'h0200, 3'd0, 16'h0, 16'h0, 3'd0, rdy, got);
    model_last = 0;
    // Now in EXEC: reset here, with both requesters already waiting.
    rst_n = 1'b0;
    req_a[0] = 16'h0007; req_b[0] = 16'h0003; req_sel[0] = 3'd1;
    req_a[1] = 16'h0001; req_b[1] = 16'h0001; req_sel[1] = 3'd0;
    req_valid = 2'b11;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0 || rsp_data !== 17'h0 || req_ready !== 2'b00)
      begin n_bad++; $display("FAIL midrst_state got valid=%b data=%h ready=%b exp 0/0/00", rsp_valid, rsp_data, req_ready); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_last = 1;
    @(negedge clk);
    n_cmp++; if (req_ready !== ((ref_winner(2'b11) == 1) ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL midrst_first_grant got=%b exp=01", req_ready); end
    model_last = 0;
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    get_rsp(got, d, id, e, lat);
    n_cmp++; if (!got || d !== 17'h00004 || id !== 1'b0) begin n_bad++; $display("FAIL midrst_rsp got=%h/id%b exp=00004/id0", d, id); end
  endtask

  task automatic test_random();
    logic [1:0] rdy; bit got; logic [1:0] v; int w; int stall;
    logic [1:0][15:0] ra; logic [1:0][15:0] rb; logic [1:0][2:0] rs;
    logic [16:0] exp_d;
    for (int it = 0; it < 40; it++) begin
      v = 2'($urandom_range(1, 3));
      for (int r = 0; r < 2; r++) begin
        ra[r] = 16'($urandom);
        rb[r] = 16'($urandom);
        rs[r] = 3'($urandom_range(0, 7));
      end
      accept_one(v, ra[0], rb[0], rs[0], ra[1], rb[1], rs[1], rdy, got);
      w = ref_winner(v);
      n_cmp++; if (!got || rdy !== ((w == 1) ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL rand_grant_%0d valid=%b got=%b exp_winner=%0d", it, v, rdy, w); end
      model_last = w;
      exp_d = ref_alu(ra[w], rb[w], rs[w]);
      stall = $urandom_range(0, 3);
      rsp_ready = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (rsp_valid) begin got = 1'b1; break; end
      end
      repeat (stall) @(negedge clk);
      n_cmp++; if (!got || rsp_valid !== 1'b1 || rsp_data !== exp_d || rsp_id !== w[0])
        begin n_bad++; $display("FAIL rand_rsp_%0d got=%h/id%b exp=%h/id%0d", it, rsp_data, rsp_id, exp_d, w); end
`ifdef ALU16_ARB_ERR_EN
      n_cmp++; if (rsp_err !== (rs[w] > 3'd4)) begin n_bad++; $display("FAIL rand_err_%0d got=%b exp=%b", it, rsp_err, (rs[w] > 3'd4)); end
`endif
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_carry();
    test_sub_borrow();
    test_round_robin();
    test_back_pressure();
    test_illegal();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_alu16_arbiter
`default_nettype wire
